xform_arbiter: RTL and testbench

- Shares one vector-matrix transform engine (start/done handshake, x/y/z in, x/y/z out, shared 4x4 matrix) among NUM_REQ requesters.
- Typical requesters: vertex fetch, camera/light setup, debug port.
- Round-robin arbitration; operand capture and hold for the whole operation; engine sequencing; response routing by ID.
- Timeout watchdog, and a post-reset drain because the engine has no reset input.

---
 rtl/xform_arbiter_if.sv | 46 ++++
 rtl/xform_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_xform_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xform_arbiter_if.sv
// Signal bundle between the transform-engine arbiter, its requesters and the engine.
// slave is the arbiter's view; master is the environment (requesters + engine).
interface xform_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_x;
  logic [NUM_REQ*32-1:0] req_y;
  logic [NUM_REQ*32-1:0] req_z;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_x;
  logic [31:0]           resp_y;
  logic [31:0]           resp_z;
  logic                  resp_err;
  logic                  err_sticky;
  logic                  mtx_lock;

  logic                  eng_start;
  logic [31:0]           eng_x;
  logic [31:0]           eng_y;
  logic [31:0]           eng_z;
  logic                  eng_done;
  logic [31:0]           eng_x_out;
  logic [31:0]           eng_y_out;
  logic [31:0]           eng_z_out;

  modport slave (
    input  req_valid, req_x, req_y, req_z,
    input  eng_done, eng_x_out, eng_y_out, eng_z_out,
    output req_ready,
    output resp_valid, resp_id, resp_x, resp_y, resp_z, resp_err, err_sticky, mtx_lock,
    output eng_start, eng_x, eng_y, eng_z
  );

  modport master (
    output req_valid, req_x, req_y, req_z,
    output eng_done, eng_x_out, eng_y_out, eng_z_out,
    input  req_ready,
    input  resp_valid, resp_id, resp_x, resp_y, resp_z, resp_err, err_sticky, mtx_lock,
    input  eng_start, eng_x, eng_y, eng_z
  );
endinterface

// File: rtl/xform_arbiter.sv
// Round-robin arbiter sharing one vector-matrix transform engine among NUM_REQ requesters,
// with operand hold, timeout watchdog and a post-reset drain for the reset-less engine.
module xform_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  xform_arbiter_if.slave bus
);
  localparam int W     = 32;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DRAIN     = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    win_s;
  logic [ID_W-1:0]    idx_s;
  logic               found_s;
  logic               tmo_hit_s;
  logic               tmo_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [CNT_W-1:0]   cnt_r;

  logic [W-1:0]       eng_x_r;
  logic [W-1:0]       eng_y_r;
  logic [W-1:0]       eng_z_r;
  logic [W-1:0]       resp_x_r;
  logic [W-1:0]       resp_y_r;
  logic [W-1:0]       resp_z_r;
  logic [ID_W-1:0]    resp_id_r;
  logic               resp_valid_r;
  logic               resp_err_r;
  logic               err_sticky_r;
  logic               mtx_lock_r;
  logic               eng_start_r;

  // Counter is cleared in ISSUE, so this compare marks the edge on which it reaches TIMEOUT-1.
  assign tmo_hit_s = (cnt_r == CNT_W'(TIMEOUT - 2));

  // Round-robin winner search beginning at rr_ptr_r.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic and the combinational accept pulse.
  always_comb begin
    state_s     = state_r;
    tmo_s       = 1'b0;
    req_ready_s = '0;
    case (state_r)
      DRAIN: begin
        if (bus.eng_done) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      IDLE: begin
        if (found_s) begin
          state_s            = ISSUE;
          req_ready_s[win_s] = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // done is still high from the previous op in the start cycle; wait for it to drop
        if (!bus.eng_done) begin
          state_s = WAIT_DONE;
        end else if (tmo_hit_s) begin
          state_s = RESPOND;
          tmo_s   = 1'b1;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (bus.eng_done) begin
          state_s = RESPOND;
        end else if (tmo_hit_s) begin
          state_s = RESPOND;
          tmo_s   = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RESPOND: begin
        if (resp_err_r) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = DRAIN;
      end
    endcase
  end

  // FSM state, round-robin pointer, watchdog counter and strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= DRAIN;
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      eng_start_r  <= 1'b0;
      mtx_lock_r   <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      eng_start_r  <= (state_s == ISSUE);
      mtx_lock_r   <= (state_s inside {ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND});
      resp_valid_r <= (state_s == RESPOND);
      if (state_r == IDLE && found_s) begin
        rr_ptr_r <= ID_W'((int'(win_s) + 32'sd1) % NUM_REQ);
      end
      if (state_r == ISSUE) begin
        cnt_r <= '0;
      end else if (state_r == WAIT_BUSY || state_r == WAIT_DONE) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Operand capture on grant and result / error capture on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_r         <= '0;
      eng_x_r      <= '0;
      eng_y_r      <= '0;
      eng_z_r      <= '0;
      resp_id_r    <= '0;
      resp_x_r     <= '0;
      resp_y_r     <= '0;
      resp_z_r     <= '0;
      resp_err_r   <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      if (state_r == IDLE && found_s) begin
        id_r    <= win_s;
        eng_x_r <= bus.req_x[W*win_s +: W];
        eng_y_r <= bus.req_y[W*win_s +: W];
        eng_z_r <= bus.req_z[W*win_s +: W];
      end
      if (state_r == ISSUE) begin
        resp_err_r <= 1'b0;
      end
      if (tmo_s) begin
        resp_x_r     <= '0;
        resp_y_r     <= '0;
        resp_z_r     <= '0;
        resp_err_r   <= 1'b1;
        err_sticky_r <= 1'b1;
      end else if (state_r == WAIT_DONE && bus.eng_done) begin
        resp_x_r <= bus.eng_x_out;
        resp_y_r <= bus.eng_y_out;
        resp_z_r <= bus.eng_z_out;
      end
      if (state_s == RESPOND) begin
        resp_id_r <= id_r;
      end
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_x     = resp_x_r;
  assign bus.resp_y     = resp_y_r;
  assign bus.resp_z     = resp_z_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.mtx_lock   = mtx_lock_r;
  assign bus.eng_start  = eng_start_r;
  assign bus.eng_x      = eng_x_r;
  assign bus.eng_y      = eng_y_r;
  assign bus.eng_z      = eng_z_r;
endmodule

// File: tb/tb_xform_arbiter.sv
// Bench for xform_arbiter: engine model, transaction-level reference monitor,
// directed scenarios and a randomized request phase.
module tb_xform_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int TIMEOUT  = 255;
  localparam int L        = 70;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STUCK  = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   eng_mode = M_NORMAL;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xform_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  xform_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dbl(input logic [31:0] f);
    dbl = {f[31], f[30:23] + 8'd1, f[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    rnd_fp = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 200)), 23'($urandom)};
  endfunction

  // Engine model: done drops one cycle after start, rises L cycles after start (mode-dependent).
  logic        e_done = 1'b1;
  bit          e_busy = 1'b0;
  int          e_cnt  = 0;
  logic [95:0] e_op   = '0;
  logic [95:0] e_res  = '0;
  assign bus.eng_done  = e_done;
  assign bus.eng_x_out = e_res[95:64];
  assign bus.eng_y_out = e_res[63:32];
  assign bus.eng_z_out = e_res[31:0];

  always @(posedge clk) begin
    if (bus.eng_start) begin
      e_cnt  <= 1;
      e_busy <= (eng_mode != M_STUCK);
      e_done <= (eng_mode == M_STUCK);
      e_op   <= {bus.eng_x, bus.eng_y, bus.eng_z};
    end else if (e_busy) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt >= L - 1 && eng_mode == M_NORMAL) begin
        e_done <= 1'b1;
        e_busy <= 1'b0;
        e_res  <= {dbl(e_op[95:64]), dbl(e_op[63:32]), dbl(e_op[31:0])};
      end
    end
  end

  // Reference monitor: transaction-level expectations derived from the round-robin rule.
  int          m_rr     = 0;
  bit          m_sticky = 1'b0;
  bit          inflight = 1'b0;
  int          n_grants = 0;
  int          cur_id   = 0;
  int          cur_t    = 0;
  bit          cur_err  = 1'b0;
  logic [95:0] cur_op   = '0;

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    pick = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick < 0 && v[(p + k) % NUM_REQ]) pick = (p + k) % NUM_REQ;
    end
  endfunction

  initial begin
    int w;
    logic [NUM_REQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_rr = 0; m_sticky = 1'b0; inflight = 1'b0;
      end else begin
        check_eq("lock", bus.mtx_lock, inflight && cyc > cur_t);
        if (inflight && cyc > cur_t)
          check_eq("eng_hold", {bus.eng_x, bus.eng_y, bus.eng_z}, cur_op);
        if (bus.eng_start) check_eq("start_time", cyc, cur_t + 1);
        if (bus.resp_valid) begin
          if (!inflight) begin
            check_eq("resp_unexpected", 1, 0);
          end else begin
            check_eq("resp_id", bus.resp_id, cur_id);
            check_eq("resp_err", bus.resp_err, cur_err);
            check_eq("resp_data", {bus.resp_x, bus.resp_y, bus.resp_z},
                     cur_err ? 96'd0 : {dbl(cur_op[95:64]), dbl(cur_op[63:32]), dbl(cur_op[31:0])});
            check_eq("resp_latency", cyc - cur_t, cur_err ? TIMEOUT + 1 : L + 2);
            if (cur_err) m_sticky = 1'b1;
            inflight = 1'b0;
          end
        end
        check_eq("sticky", bus.err_sticky, m_sticky);
        if (bus.req_ready != '0) begin
          w  = pick(bus.req_valid, m_rr);
          oh = (w < 0) ? '0 : (NUM_REQ'(1) << w);
          check_eq("grant", bus.req_ready, oh);
          if (w >= 0) begin
            cur_id   = w;
            cur_t    = cyc;
            cur_err  = (eng_mode != M_NORMAL);
            cur_op   = {bus.req_x[32*w +: 32], bus.req_y[32*w +: 32], bus.req_z[32*w +: 32]};
            inflight = 1'b1;
            m_rr     = (w + 1) % NUM_REQ;
            n_grants++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i);
    bus.req_x[32*i +: 32] = rnd_fp();
    bus.req_y[32*i +: 32] = rnd_fp();
    bus.req_z[32*i +: 32] = rnd_fp();
  endtask

  task automatic wait_grant(input int limit, output int gcyc, output logic [NUM_REQ-1:0] gv);
    gcyc = -1;
    gv   = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        gcyc = cyc;
        gv   = bus.req_ready;
        break;
      end
    end
    if (gcyc < 0) check_eq("grant_timeout", 0, 1);
  endtask

  task automatic wait_resp(input int limit, output int rcyc, output int rid,
                           output logic [95:0] rdata, output logic rerr);
    rcyc = -1; rid = -1; rdata = '0; rerr = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rcyc  = cyc;
        rid   = int'(bus.resp_id);
        rdata = {bus.resp_x, bus.resp_y, bus.resp_z};
        rerr  = bus.resp_err;
        break;
      end
    end
    if (rcyc < 0) check_eq("resp_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (!inflight) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    int t, r, rid, g, d, n0;
    int gc[5];
    logic [NUM_REQ-1:0] gv, gr;
    logic [95:0] rdata;
    logic rerr;

    // Reset state, with every requester asserting
    bus.req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i);
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_err,
                         bus.err_sticky, bus.mtx_lock, bus.eng_start}, 0);
    check_eq("rst_resp", {bus.resp_x, bus.resp_y, bus.resp_z}, 0);
    check_eq("rst_eng", {bus.eng_x, bus.eng_y, bus.eng_z}, 0);
    bus.req_valid = '0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) tick();

    // Single request 1.0/2.0/3.0 from requester 0
    bus.req_x[31:0] = 32'h3f800000;
    bus.req_y[31:0] = 32'h40000000;
    bus.req_z[31:0] = 32'h40400000;
    bus.req_valid   = 4'b0001;
    wait_grant(20, t, gv);
    check_eq("t1_ready", gv, 4'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check_eq("t1_start", bus.eng_start, 1'b1);
    wait_resp(200, r, rid, rdata, rerr);
    check_eq("t1_latency", r - t, 72);
    check_eq("t1_id", rid, 0);
    check_eq("t1_data", rdata, {32'h40000000, 32'h40800000, 32'h40C00000});
    check_eq("t1_err", rerr, 1'b0);
    wait_idle(50);

    // Requester 3 alone: pointer wraps back to 0
    tick();
    set_req(3);
    bus.req_valid = 4'b1000;
    wait_grant(20, t, gv);
    check_eq("wrap_ready", gv, 4'b1000);
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    // All four held valid: order 0,1,2,3,0 spaced L+3 cycles
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_req(i);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(200, gc[k], gv);
      gr = NUM_REQ'(1) << (k % NUM_REQ);
      check_eq("rr_order", gv, gr);
      if (k > 0) check_eq("rr_spacing", gc[k] - gc[k-1], L + 3);
    end
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    // rr_ptr=2 with 0011: requester 0 wins, then requester 1
    tick();
    bus.req_valid = 4'b0010;
    wait_grant(20, t, gv);
    tick();
    bus.req_valid = '0;
    wait_idle(200);
    tick();
    bus.req_valid = 4'b0011;
    wait_grant(20, t, gv);
    check_eq("rr2_grant", gv, 4'b0001);
    tick();
    bus.req_valid = 4'b0010;
    wait_grant(200, t, gv);
    check_eq("rr1_grant", gv, 4'b0010);
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    // Randomized requests against the reference monitor
    tick();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = int'(bus.req_ready);
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
          else set_req(i);
        end else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i);
          bus.req_valid[i] = 1'b1;
        end
      end
    end
    bus.req_valid = '0;
    wait_idle(300);

    // Engine never raises done: timeout, sticky error, drain blocks grants
    eng_mode = M_NEVER;
    tick();
    set_req(0);
    bus.req_valid = 4'b0001;
    wait_grant(20, t, gv);
    tick();
    set_req(2);
    bus.req_valid = 4'b0100;
    wait_resp(400, r, rid, rdata, rerr);
    check_eq("tmo_latency", r - t, TIMEOUT + 1);
    check_eq("tmo_err", rerr, 1'b1);
    check_eq("tmo_data", rdata, 96'd0);
    check_eq("tmo_sticky", bus.err_sticky, 1'b1);
    @(negedge clk);
    #1 n0 = n_grants;
    repeat (30) @(negedge clk);
    #1 check_eq("drain_hold", n_grants, n0);
    tick();
    eng_mode = M_NORMAL;
    wait_grant(10, t, gv);
    check_eq("drain_release", gv, 4'b0100);
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    // Reset pulse mid-operation, then drain until the engine goes idle
    tick();
    set_req(0);
    bus.req_valid = 4'b0001;
    wait_grant(20, t, gv);
    tick();
    bus.req_valid = '0;
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_ctl", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_err,
                          bus.err_sticky, bus.mtx_lock, bus.eng_start}, 0);
    check_eq("arst_resp", {bus.resp_x, bus.resp_y, bus.resp_z}, 0);
    check_eq("arst_eng", {bus.eng_x, bus.eng_y, bus.eng_z}, 0);
    set_req(0);
    bus.req_valid = 4'b0001;
    #1 check_eq("arst_ready", bus.req_ready, 4'b0000);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    d = -1;
    g = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d < 0 && bus.eng_done) d = cyc;
      if (bus.req_ready != '0) begin
        g  = cyc;
        gv = bus.req_ready;
        break;
      end
    end
    check_eq("drain_grant_time", g, d + 1);
    check_eq("drain_grant", gv, 4'b0001);
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    // Done stuck high: no false completion, timeout from WAIT_BUSY
    eng_mode = M_STUCK;
    tick();
    set_req(1);
    bus.req_valid = 4'b0010;
    wait_grant(20, t, gv);
    tick();
    bus.req_valid = '0;
    wait_resp(400, r, rid, rdata, rerr);
    check_eq("stuck_latency", r - t, TIMEOUT + 1);
    check_eq("stuck_err", rerr, 1'b1);
    eng_mode = M_NORMAL;
    tick();
    set_req(3);
    bus.req_valid = 4'b1000;
    wait_grant(10, t, gv);
    check_eq("stuck_recover", gv, 4'b1000);
    tick();
    bus.req_valid = '0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
